mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the 5-stage pipeline's IF stage
//  (instruction fetch) and MEM stage (load/store).
//  Sits between the pipeline and the memory model. Serialises requests with a
//  3-state FSM, drives per-stage stall outputs and flags unresponsive memory via timeout.
// PARAMETERS
//  ADDR_W        32  address width
//  DATA_W        32  data width
//  TIMEOUT       16  cycles waited for ram_ack_in before a transaction is aborted (>=2)
//  MAX_MEM_WINS  4   consecutive MEM grants allowed while IF waits (only with ARB_FAIRNESS_EN)
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  reset          in   1       synchronous, active-high
//  if_req_in      in   1       IF read request, held until if_ack_out
//  if_addr_in     in   ADDR_W  IF fetch address (PC)
//  if_rdata_out   out  DATA_W  fetched instruction, valid with if_ack_out
//  if_ack_out     out  1       IF transaction complete (1-cycle pulse)
//  if_stall_out   out  1       if_req_in & ~if_ack_out
//  mem_req_in     in   1       MEM request, held until mem_ack_out
//  mem_we_in      in   1       1=store, 0=load
//  mem_addr_in    in   ADDR_W  MEM address (ALU result)
//  mem_wdata_in   in   DATA_W  store data
//  mem_rdata_out  out  DATA_W  load data, valid with mem_ack_out
//  mem_ack_out    out  1       MEM transaction complete (1-cycle pulse)
//  mem_stall_out  out  1       mem_req_in & ~mem_ack_out
//  ram_req_out    out  1       memory request, registered
//  ram_we_out     out  1       memory write enable, registered
//  ram_addr_out   out  ADDR_W  memory address, registered
//  ram_wdata_out  out  DATA_W  memory write data, registered
//  ram_rdata_in   in   DATA_W  memory read data, valid with ram_ack_in
//  ram_ack_in     in   1       memory completion
//  err_out        out  1       sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  - FSM states: IDLE, BUSY_IF, BUSY_MEM.
//  - IDLE: mem_req_in wins over if_req_in (older instruction first).
//    Grant at edge N loads ram_* regs; ram_req_out=1 from N+1.
//  - BUSY_x: ram_req/we/addr/wdata held stable until ram_ack_in.
//    In the ram_ack_in cycle: x_ack_out=1 (combinational), x_rdata_out=ram_rdata_in (pass-through).
//    Next edge: ram_req_out=0, state=IDLE. Always one IDLE cycle between transactions.
//  - Minimum latency: req seen at edge N -> ack in cycle N+1 if memory acks immediately.
//  - Loads and stores both complete on ram_ack_in. Store rdata is don't-care; drive 0.
//  - Wait counter: clears on grant, increments each BUSY cycle without ram_ack_in.
//    On reaching TIMEOUT-1 without ack: x_ack_out=1, x_rdata_out=0, err_out<=1,
//    ram_req_out<=0, state<=IDLE. A late ram_ack_in in IDLE is ignored.
//  - x_ack_out is never asserted unless the FSM is in BUSY_x. Both acks are never high together.
//  - A request dropped before ack is a protocol violation; the transaction still completes.
//  - Reset values: state=IDLE, all ram_* outputs 0, both acks 0, both rdata 0,
//    err_out 0, counters 0.
//  - Reset mid-transaction: abandoned, no ack issued, ram_req_out=0 the next cycle.
// CONFIGURATION
//  ARB_FAIRNESS_EN defined:
//    - Counts consecutive MEM grants made while if_req_in is high.
//    - After MAX_MEM_WINS such grants, the next IDLE grant goes to IF even if mem_req_in=1.
//    - Counter clears on any IF grant, or on a MEM grant made with if_req_in low.
//  ARB_FAIRNESS_EN undefined:
//    - Fixed MEM priority. IF may starve indefinitely. No counter logic is instantiated.
// TESTING
//  1. IF only, addr 0x10, memory acks 1 cycle after ram_req_out, rdata 0x00000013
//     -> ram_addr_out=0x10, ram_we_out=0; if_ack_out pulses once with if_rdata_out=0x00000013.
//  2. IF(0x10) and MEM store(0x200, 0xDEADBEEF) raised in the same cycle
//     -> first ram txn we=1, addr=0x200, wdata=0xDEADBEEF;
//     -> then one IDLE cycle, then read addr 0x10; if_stall_out=1 throughout.
//  3. mem_req_in held high continuously, IF pending
//     -> with ARB_FAIRNESS_EN: IF granted after exactly 4 MEM grants;
//     -> without it: if_ack_out never asserts over 50 cycles.
//  4. MEM load, ram_ack_in never asserted
//     -> mem_ack_out with rdata 0 after 16 BUSY cycles; err_out=1 and stays 1;
//     -> the following IF txn completes normally.
//  5. reset asserted mid BUSY_MEM
//     -> next cycle: ram_req_out=0, no acks, err_out=0;
//     -> a new IF request after reset deasserts is served normally.
//  6. Back-to-back loads, each memory ack 3 cycles after ram_req_out
//     -> each mem_ack_out is 1 cycle wide; ram_req_out is low exactly 1 cycle between txns.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port unified memory between the pipeline's IF stage
//   (instruction fetch) and MEM stage (load/store). Requests are served one at
//   a time by a 3-state FSM (IDLE, BUSY_IF, BUSY_MEM). There is always one IDLE
//   cycle between memory transactions. A wait counter aborts a transaction that
//   the memory never acknowledges and raises a sticky error flag.
//
//   Optional feature macro: ARB_FAIRNESS_EN
//     defined   : after MAX_MEM_WINS consecutive MEM grants made while IF was
//                 waiting, the next grant goes to IF.
//     undefined : fixed MEM priority; IF may starve.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   if_req_in         IF read request, held until if_ack_out
//   if_addr_in        IF fetch address
//   if_rdata_out      fetched instruction, valid with if_ack_out
//   if_ack_out        IF completion pulse (combinational)
//   if_stall_out      if_req_in & ~if_ack_out
//   mem_req_in        MEM request, held until mem_ack_out
//   mem_we_in         1 = store, 0 = load
//   mem_addr_in       MEM address
//   mem_wdata_in      store data
//   mem_rdata_out     load data, valid with mem_ack_out (0 for stores)
//   mem_ack_out       MEM completion pulse (combinational)
//   mem_stall_out     mem_req_in & ~mem_ack_out
//   ram_req_out       registered memory request
//   ram_we_out        registered memory write enable
//   ram_addr_out      registered memory address
//   ram_wdata_out     registered memory write data
//   ram_rdata_in      memory read data, valid with ram_ack_in
//   ram_ack_in        memory completion
//   err_out           sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned MAX_MEM_WINS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_rdata_out,
  output logic              if_ack_out,
  output logic              if_stall_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_ack_out,
  output logic              mem_stall_out,
  output logic              ram_req_out,
  output logic              ram_we_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_wdata_out,
  input  logic [DATA_W-1:0] ram_rdata_in,
  input  logic              ram_ack_in,
  output logic              err_out
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY_IF  = 2'd1;
  localparam logic [1:0] S_BUSY_MEM = 2'd2;

  // Reject configurations the wait counter and fairness logic cannot honour.
  if (TIMEOUT < 2 || MAX_MEM_WINS < 1) begin : g_bad_param
    $error("mem_port_arbiter: TIMEOUT must be >= 2 and MAX_MEM_WINS >= 1");
  end

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_ram_req;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_err;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_grant_if;
  logic w_grant_mem;
  logic w_force_if;

  // Transaction completion: memory ack, or the wait counter running out.
  assign w_busy    = (r_state == S_BUSY_IF) || (r_state == S_BUSY_MEM);
  assign w_timeout = w_busy && !ram_ack_in && (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign w_done    = w_busy && (ram_ack_in || w_timeout);

  // Next-state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    case (r_state)
      S_IDLE: begin
        // MEM holds the older instruction, so it wins unless fairness forces IF.
        if (mem_req_in && !w_force_if) begin
          w_grant_mem = 1'b1;
          w_state_nxt = S_BUSY_MEM;
        end else if (if_req_in) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_BUSY_IF;
        end
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory-side request registers, wait counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant_mem) begin
        r_ram_req   <= 1'b1;
        r_ram_we    <= mem_we_in;
        r_ram_addr  <= mem_addr_in;
        r_ram_wdata <= mem_wdata_in;
        r_wait_cnt  <= '0;
      end else if (w_grant_if) begin
        r_ram_req   <= 1'b1;
        r_ram_we    <= 1'b0;
        r_ram_addr  <= if_addr_in;
        r_ram_wdata <= '0;
        r_wait_cnt  <= '0;
      end else if (w_done) begin
        r_ram_req   <= 1'b0;
        r_ram_we    <= 1'b0;
        r_wait_cnt  <= '0;
      end else if (w_busy) begin
        r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned WIN_W = $clog2(MAX_MEM_WINS + 1);

  logic [WIN_W-1:0] r_win_cnt;

  assign w_force_if = if_req_in && (r_win_cnt >= WIN_W'(MAX_MEM_WINS));

  // Counts consecutive MEM grants that left IF waiting; cannot exceed
  // MAX_MEM_WINS because reaching it forces the next grant to IF.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt <= '0;
    end else if (w_grant_if) begin
      r_win_cnt <= '0;
    end else if (w_grant_mem) begin
      r_win_cnt <= if_req_in ? (r_win_cnt + WIN_W'(1)) : '0;
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Completion pulses and read-data pass-through; timed-out or store
  // transactions return zero data.
  assign if_ack_out    = (r_state == S_BUSY_IF)  && w_done;
  assign mem_ack_out   = (r_state == S_BUSY_MEM) && w_done;
  assign if_rdata_out  = (if_ack_out && ram_ack_in) ? ram_rdata_in : '0;
  assign mem_rdata_out = (mem_ack_out && ram_ack_in && !r_ram_we) ? ram_rdata_in : '0;

  assign if_stall_out  = if_req_in  && !if_ack_out;
  assign mem_stall_out = mem_req_in && !mem_ack_out;

  assign ram_req_out   = r_ram_req;
  assign ram_we_out    = r_ram_we;
  assign ram_addr_out  = r_ram_addr;
  assign ram_wdata_out = r_ram_wdata;
  assign err_out       = r_err;

endmodule
